// File: rtl/matrix_server.sv
// Operand store and row/column fetch stage for the 32x32 8-bit matrix engine.
// Define MSERVE_CHECKSUM_EN to add the checksum_out port and its load-byte accumulator.
module matrix_server #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 8
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                load_start,
  input  logic                load_valid,
  input  logic [W-1:0]        load_data,
  output logic                load_ready,
  output logic                complete,
  input  logic                new_request,
  input  logic [4:0]          row_req,
  input  logic [4:0]          col_req,
  output logic [N-1:0][W-1:0] matA_row,
  output logic [N-1:0][W-1:0] matB_col,
  output logic [4:0]          row_in,
  output logic [4:0]          col_in,
  output logic                val_rows
`ifdef MSERVE_CHECKSUM_EN
  ,
  output logic [15:0]         checksum_out
`endif
);

  typedef enum logic [2:0] {StEmpty, StLoad, StIdle, StRead, StResp} state_e;

  state_e r_state;
  state_e w_state_d;

  logic [10:0]         r_cnt;
  logic [4:0]          r_row;
  logic [4:0]          r_col;
  logic [N-1:0][W-1:0] r_a_rows [N];
  logic [N-1:0][W-1:0] r_b_cols [N];

  logic w_accept;
  logic w_last;
  logic w_load_ready_d;
  logic w_complete_d;
  logic w_val_d;
  logic w_req_cap;

  // load_start pre-empts any transfer, so a byte offered alongside it is not taken.
  assign w_accept = load_valid & load_ready & ~load_start;
  assign w_last   = w_accept & (r_cnt == 11'h7ff);

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    if (load_start) begin
      w_state_d = StLoad;
    end else begin
      unique case (r_state)
        StEmpty: w_state_d = StEmpty;
        StLoad:  if (w_last) w_state_d = StIdle;
        StIdle:  if (new_request) w_state_d = StRead;
        StRead:  w_state_d = StResp;
        StResp:  w_state_d = StIdle;
        default: w_state_d = StEmpty;
      endcase
    end
  end

  // Output decode, registered below
  always_comb begin
    w_load_ready_d = (w_state_d == StLoad);
    w_complete_d   = complete;
    if (load_start) begin
      w_complete_d = 1'b0;
    end else if (w_last) begin
      w_complete_d = 1'b1;
    end
    w_val_d   = (r_state == StRead) & ~load_start;
    w_req_cap = (r_state == StIdle) & new_request & ~load_start;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt      <= '0;
      r_row      <= '0;
      r_col      <= '0;
      load_ready <= 1'b0;
      complete   <= 1'b0;
      val_rows   <= 1'b0;
      row_in     <= '0;
      col_in     <= '0;
      matA_row   <= '0;
      matB_col   <= '0;
    end else begin
      load_ready <= w_load_ready_d;
      complete   <= w_complete_d;
      val_rows   <= w_val_d;
      if (load_start) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 11'd1;
      end
      if (w_req_cap) begin
        r_row <= row_req;
        r_col <= col_req;
      end
      if (w_val_d) begin
        matA_row <= r_a_rows[r_row];
        matB_col <= r_b_cols[r_col];
        row_in   <= r_row;
        col_in   <= r_col;
      end
    end
  end

  // Operand storage is not reset; B arrives row-major and is stored transposed.
  always_ff @(posedge clk_in) begin
    if (w_accept) begin
      if (!r_cnt[10]) begin
        r_a_rows[r_cnt[9:5]][r_cnt[4:0]] <= load_data;
      end else begin
        r_b_cols[r_cnt[4:0]][r_cnt[9:5]] <= load_data;
      end
    end
  end

`ifdef MSERVE_CHECKSUM_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      checksum_out <= '0;
    end else if (load_start) begin
      checksum_out <= '0;
    end else if (w_accept) begin
      checksum_out <= checksum_out + {{(16 - W){1'b0}}, load_data};
    end
  end
`endif

endmodule

// File: tb/tb_matrix_server.sv
// Directed, table-driven bench for matrix_server: loads, fetches, aborts and resets.
module tb_matrix_server;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             load_start;
  logic             load_valid;
  logic [7:0]       load_data;
  logic             load_ready;
  logic             complete;
  logic             new_request;
  logic [4:0]       row_req;
  logic [4:0]       col_req;
  logic [31:0][7:0] matA_row;
  logic [31:0][7:0] matB_col;
  logic [4:0]       row_in;
  logic [4:0]       col_in;
  logic             val_rows;
`ifdef MSERVE_CHECKSUM_EN
  logic [15:0]      checksum_out;
`endif

  always #5 clk_in = ~clk_in;

  matrix_server #(.N(32), .W(8)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .complete    (complete),
    .new_request (new_request),
    .row_req     (row_req),
    .col_req     (col_req),
    .matA_row    (matA_row),
    .matB_col    (matB_col),
    .row_in      (row_in),
    .col_in      (col_in),
    .val_rows    (val_rows)
`ifdef MSERVE_CHECKSUM_EN
    ,
    .checksum_out(checksum_out)
`endif
  );

  typedef struct {
    logic [4:0] r;
    logic [4:0] c;
    logic [7:0] a0;
    logic [7:0] a31;
    logic [7:0] b0;
    logic [7:0] b31;
  } vec_t;

  vec_t       tbl [5];
  logic [7:0] a_m [32][32];
  logic [7:0] b_m [32][32];  // row-major, as streamed
  logic [15:0] csum_m;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [255:0] row_of(input int r);
    logic [255:0] v;
    for (int k = 0; k < 32; k++) v[k*8 +: 8] = a_m[r][k];
    return v;
  endfunction

  function automatic logic [255:0] col_of(input int c);
    logic [255:0] v;
    for (int k = 0; k < 32; k++) v[k*8 +: 8] = b_m[k][c];
    return v;
  endfunction

  function automatic logic [7:0] pat(input int i);
    int r;
    int c;
    r = (i >> 5) & 31;
    c = i & 31;
    if (i < 1024) return 8'(r + c);
    return 8'(r ^ c);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_load_ready"}, load_ready, 0);
    chk({tag, "_complete"}, complete, 0);
    chk({tag, "_val_rows"}, val_rows, 0);
    chk({tag, "_row_in"}, row_in, 0);
    chk({tag, "_col_in"}, col_in, 0);
    chk({tag, "_matA_row"}, matA_row, 0);
    chk({tag, "_matB_col"}, matB_col, 0);
`ifdef MSERVE_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum_out, 0);
`endif
  endtask

  // Called from a non-LOAD state, so the junk byte offered with load_start is dropped.
  task automatic start_load();
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h5a;
    csum_m     = '0;
    step();
    load_start = 1'b0;
    load_valid = 1'b0;
    chk("load_ready_after_start", load_ready, 1);
  endtask

  // mode 0: A=r+c / B=r^c, 1: all 0xFF, 2: random bytes
  task automatic stream(input int mode, input bit gaps);
    int         acc;
    int         cyc;
    logic       v;
    logic [7:0] d;
    acc = 0;
    cyc = 0;
    while (acc < 2048 && cyc < 20000) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = (mode == 0) ? pat(acc) : (mode == 1) ? 8'hff : 8'($urandom);
      load_valid = v;
      load_data  = v ? d : 8'($urandom);
      if (v && acc == 2047) chk("complete_before_last", complete, 0);
      step();
      cyc++;
      if (v) begin
        if (acc < 1024) a_m[(acc >> 5) & 31][acc & 31] = d;
        else b_m[(acc >> 5) & 31][acc & 31] = d;
        csum_m = csum_m + 16'(d);
        acc++;
      end
    end
    load_valid = 1'b0;
    chk("load_byte_count", acc, 2048);
    chk("complete_after_last", complete, 1);
    chk("load_ready_drop", load_ready, 0);
`ifdef MSERVE_CHECKSUM_EN
    chk("checksum_final", checksum_out, csum_m);
`endif
  endtask

  task automatic req(input int r, input int c);
    new_request = 1'b1;
    row_req     = 5'(r);
    col_req     = 5'(c);
    step();
    new_request = 1'b0;
    chk("req_val_early", val_rows, 0);
    step();
    chk("req_val_pulse", val_rows, 1);
    chk("req_row_in", row_in, r);
    chk("req_col_in", col_in, c);
    chk("req_matA_row", matA_row, row_of(r));
    chk("req_matB_col", matB_col, col_of(c));
    step();
    chk("req_val_end", val_rows, 0);
  endtask

  initial begin
    int cyc;
    int last;
    int idx;

    tbl[0] = '{r: 5'd3,  c: 5'd7,  a0: 8'd3,  a31: 8'd34, b0: 8'd7,  b31: 8'd24};
    tbl[1] = '{r: 5'd0,  c: 5'd0,  a0: 8'd0,  a31: 8'd31, b0: 8'd0,  b31: 8'd31};
    tbl[2] = '{r: 5'd31, c: 5'd31, a0: 8'd31, a31: 8'd62, b0: 8'd31, b31: 8'd0};
    tbl[3] = '{r: 5'd16, c: 5'd5,  a0: 8'd16, a31: 8'd47, b0: 8'd5,  b31: 8'd26};
    tbl[4] = '{r: 5'd10, c: 5'd21, a0: 8'd10, a31: 8'd41, b0: 8'd21, b31: 8'd10};

    rst_n_in    = 1'b0;
    load_start  = 1'b0;
    load_valid  = 1'b0;
    load_data   = '0;
    new_request = 1'b0;
    row_req     = '0;
    col_req     = '0;
    repeat (3) @(posedge clk_in);
    #1;
    chk_reset("por");
    rst_n_in = 1'b1;
    step();

    // Requests are ignored while empty
    new_request = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("empty_no_val", val_rows, 0);
      chk("empty_no_ready", load_ready, 0);
    end
    new_request = 1'b0;

    start_load();
    stream(0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      req(tbl[i].r, tbl[i].c);
      chk("tbl_a_lane0", matA_row[0], tbl[i].a0);
      chk("tbl_a_lane31", matA_row[31], tbl[i].a31);
      chk("tbl_b_lane0", matB_col[0], tbl[i].b0);
      chk("tbl_b_lane31", matB_col[31], tbl[i].b31);
    end

    // Back-to-back sweep, index advanced on the cycle val_rows is seen
    cyc = 0;
    last = 0;
    idx = 0;
    new_request = 1'b1;
    row_req = '0;
    col_req = '0;
    while (idx < 1024 && cyc < 4000) begin
      step();
      cyc++;
      if (val_rows) begin
        chk("sweep_row_in", row_in, idx >> 5);
        chk("sweep_col_in", col_in, idx & 31);
        chk("sweep_matA_row", matA_row, row_of(idx >> 5));
        chk("sweep_matB_col", matB_col, col_of(idx & 31));
        if (idx > 0) chk("sweep_spacing", cyc - last, 3);
        last = cyc;
        idx++;
        row_req = 5'(idx >> 5);
        col_req = 5'(idx);
      end
    end
    new_request = 1'b0;
    chk("sweep_count", idx, 1024);
    step();
    chk("sweep_idle_val", val_rows, 0);

    // load_start in the READ cycle drops the request
    new_request = 1'b1;
    row_req = 5'd1;
    col_req = 5'd2;
    step();
    new_request = 1'b0;
    load_start = 1'b1;
    csum_m = '0;
    step();
    load_start = 1'b0;
    chk("abort_no_val", val_rows, 0);
    chk("abort_complete", complete, 0);
    chk("abort_load_ready", load_ready, 1);
    stream(2, 1'b1);

    // Junk while load_ready is low must not land anywhere
    load_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      load_data = 8'($urandom);
      step();
    end
    load_valid = 1'b0;
`ifdef MSERVE_CHECKSUM_EN
    chk("checksum_after_junk", checksum_out, csum_m);
`endif
    for (int i = 0; i < 32; i++) req(i, 31 - i);

`ifdef MSERVE_CHECKSUM_EN
    start_load();
    stream(1, 1'b0);
    chk("checksum_all_ff", checksum_out, 16'hf800);
`endif

    // Asynchronous reset mid-load
    start_load();
    load_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      load_data = pat(i);
      step();
    end
    load_valid = 1'b0;
    #2 rst_n_in = 1'b0;
    #1 chk_reset("rst_mid_load");
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    new_request = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_empty_ready", load_ready, 0);
      chk("post_rst_empty_val", val_rows, 0);
    end
    new_request = 1'b0;

    // Asynchronous reset mid-request, while val_rows is high
    start_load();
    stream(0, 1'b0);
    new_request = 1'b1;
    row_req = 5'd3;
    col_req = 5'd7;
    step();
    new_request = 1'b0;
    step();
    chk("pre_rst_val", val_rows, 1);
    #2 rst_n_in = 1'b0;
    #1 chk_reset("rst_mid_req");
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    new_request = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst2_val", val_rows, 0);
      chk("post_rst2_complete", complete, 0);
      chk("post_rst2_ready", load_ready, 0);
    end
    new_request = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_server.md
# matrix_server

Upstream storage and fetch stage for the 32x32 8-bit matrix engine. It ingests matrices A and B as a byte stream and holds A as 32 packed rows and B as 32 packed columns. It then answers single-outstanding row/column fetch requests from the algorithm stage. It raises `complete` once both operands are resident, and this rising edge starts the algorithm stage.

## Interface
Parameters:
- `N`, 32, matrix dimension. Only 32 is supported; it sets the index width at 5 bits.
- `W`, 8, element width in bits.

Ports:
- `clk_in`  input  1  system clock
- `rst_n_in`  input  1  reset, asynchronous, active-low
- `load_start`  input  1  one-cycle pulse that begins a new A+B load
- `load_valid`  input  1  `load_data` is valid this cycle
- `load_data`  input  8  stream byte
- `load_ready`  output  1  server accepts a byte this cycle
- `complete`  output  1  high while both matrices are fully loaded
- `new_request`  input  1  fetch request
- `row_req`  input  5  A row index
- `col_req`  input  5  B column index
- `matA_row`  output  [31:0][7:0]  A row; lane k = A[row][k]
- `matB_col`  output  [31:0][7:0]  B column; lane k = B[k][col]
- `row_in`  output  5  echo of the served row index
- `col_in`  output  5  echo of the served column index
- `val_rows`  output  1  one-cycle pulse; data and indices are valid
- `checksum_out`  output  16  only present with `MSERVE_CHECKSUM_EN`

## Operation
- Storage is two register arrays: `a_rows[32]` and `b_cols[32]`, each 256 bits wide.
- States: `EMPTY`, `LOAD`, `IDLE`, `READ`, `RESP`.
- `EMPTY` → `LOAD` on `load_start`.
- In `LOAD`, `load_ready` is 1. Each byte where `load_valid && load_ready` is true is written at the position given by an 11-bit counter `cnt`:
  - `cnt[10]=0` → A: row `cnt[9:5]`, lane `cnt[4:0]`.
  - `cnt[10]=1` → B: lane `cnt[9:5]` of `b_cols[cnt[4:0]]`.
  - Both matrices arrive row-major; the server transposes B.
- When the accepted byte has `cnt==2047`: go to `IDLE`, set `complete`=1, and let `cnt` wrap to 0.
- In `IDLE`, if `new_request` is high, capture `row_req`/`col_req` and go to `READ`.
- In `READ`, register `a_rows[r]`, `b_cols[c]` and the indices to the outputs, set `val_rows`=1, and go to `RESP`.
- In `RESP`, set `val_rows`=0 and go to `IDLE`.
- `new_request` is sampled only in `IDLE`. It is ignored in `EMPTY`, `LOAD`, `READ` and `RESP`.
- Data outputs hold their last served value until the next response.
- `load_start` in any state, including mid-load or mid-request, has priority:
  - `cnt`, `complete` and `val_rows` go to 0.
  - The state goes to `LOAD`.
  - Any in-flight request is dropped with no `val_rows`.
  - Stored contents are overwritten progressively, not cleared.
- Bytes offered while `load_ready`=0 are dropped and not counted.

## Timing
- Reset values:
  - state=`EMPTY`, `cnt`=0.
  - `load_ready`=0, `complete`=0, `val_rows`=0.
  - `row_in`=`col_in`=0; `matA_row`=`matB_col`=0.
  - `checksum_out`=0.
  - Array contents are not reset.
- `load_ready` is a registered decode of the state. It is high in the cycle after `load_start`.
- `complete` rises in the cycle after the 2048th accepted byte.
- Request latency:
  - `new_request` sampled in `IDLE` at cycle N gives `val_rows`=1 in cycle N+2.
  - The next sample is in cycle N+3.
  - A consumer that updates `row_req`/`col_req` on the edge where it sees `val_rows` is therefore sampled with the new index.
- Sustained throughput: one response every 3 cycles.
- If `new_request` and `load_start` occur in the same cycle, `load_start` wins and the request is lost.
- Deasserting `rst_n_in` mid-operation forces all reset values immediately (asynchronous).

## Configuration
- `MSERVE_CHECKSUM_EN` defined:
  - A 16-bit wrapping sum of all accepted load bytes accumulates into `checksum_out`.
  - It clears to 0 on `load_start` and on reset.
  - It is final when `complete` rises and stays stable until the next `load_start`.
- Undefined: the `checksum_out` port and its adder are absent. All other behaviour is identical.

## Test plan
- Reset, then a 2048-byte load with A[r][c]=r+c and B[r][c]=r^c, `load_valid` always high → `complete` rises exactly 1 cycle after the last byte; `load_ready` then drops to 0.
- Request `row_req`=3, `col_req`=7 → two cycles later `val_rows` pulses for one cycle with `row_in`=3, `col_in`=7, `matA_row[k]`=3+k, `matB_col[k]`=k^7.
- `new_request` held high while a consumer steps through all 1024 (row, col) pairs → 1024 `val_rows` pulses spaced 3 cycles apart, in order, with no repeated or skipped index.
- `load_start` asserted in the `READ` cycle → no `val_rows`, `complete`=0 the next cycle, and the new load proceeds from `cnt`=0.
- Load with random `load_valid` gaps and junk bytes presented while `load_ready`=0 → stored contents match only the accepted bytes. With `MSERVE_CHECKSUM_EN`, `checksum_out` equals the mod-65536 sum of the accepted bytes (all-0xFF load gives 0xF800).
- `rst_n_in` pulsed low mid-load and mid-request → all outputs take their reset values within the same cycle, and the block stays in `EMPTY` until `load_start`.
